// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes
module alu_muldiv_seq #(
  parameter int XLEN = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int N = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  if (!(XLEN == 32 || XLEN == 64) || !(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) || (XLEN % BITS_PER_CYCLE) != 0) begin : g_bad_param
    $error("alu_muldiv_seq: unsupported XLEN/BITS_PER_CYCLE combination");
  end
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  state_e            state_q;
  logic [2:0]        f3_q;
  logic              sa_q, sb_q;
  logic [XLEN-1:0]   opnd_q, result_q;
  logic [2*XLEN-1:0] acc_q, acc_d, prod_s;
  logic [CW-1:0]     cnt_q;
  logic              sgn_a, sgn_b, sa, sb, ovf, special;
  logic [XLEN-1:0]   ma, mb, spec_res, calc_res;
  logic [XLEN:0]     rp, diff, sum;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign result    = result_q;
  // Operand decode at acceptance: signedness, magnitudes and the divide corner cases
  always_comb begin
    sgn_a    = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
    sgn_b    = funct3[2] ? !funct3[0] : !funct3[1];
    sa       = sgn_a & op_a[XLEN-1];
    sb       = sgn_b & op_b[XLEN-1];
    ma       = sa ? -op_a : op_a;
    mb       = sb ? -op_b : op_b;
    ovf      = funct3[2] & !funct3[0] & (op_a == MIN) & (&op_b);
    special  = funct3[2] & ((op_b == '0) | ovf);
    spec_res = (op_b == '0) ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : MIN);
  end
  // One CALC edge worth of shift-add multiply or restoring divide steps, then sign fix-up
  always_comb begin
    acc_d = acc_q;
    rp    = '0;
    diff  = '0;
    sum   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rp    = acc_d[2*XLEN-1:XLEN-1];
      diff  = rp - {1'b0, opnd_q};
      sum   = {1'b0, acc_d[2*XLEN-1:XLEN]} + ({(XLEN+1){acc_d[0]}} & {1'b0, opnd_q});
      acc_d = f3_q[2] ? {diff[XLEN] ? rp[XLEN-1:0] : diff[XLEN-1:0], acc_d[XLEN-2:0], !diff[XLEN]}
                      : {sum, acc_d[XLEN-1:1]};
    end
    prod_s   = (sa_q ^ sb_q) ? -acc_d : acc_d;
    calc_res = f3_q[2] ? (f3_q[1] ? (sa_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN])
                                  : ((sa_q ^ sb_q) ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0]))
                       : (f3_q[1:0] == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
  end
  // Control FSM and datapath registers; flush aborts to IDLE keeping the last result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          f3_q    <= funct3;
          sa_q    <= sa;
          sb_q    <= sb;
          opnd_q  <= funct3[2] ? mb : ma;
          acc_q   <= {{XLEN{1'b0}}, funct3[2] ? ma : mb};
          cnt_q   <= CW'(N);
          state_q <= special ? DONE : CALC;
          if (special) result_q <= spec_res;
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q  <= DONE;
            result_q <= calc_res;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Iterative RV32M/RV64M multiply/divide unit that runs beside the single-cycle ALU in the execute stage.
- Handles the ops with opcode OP and funct7=0000001 (the M-extension slots).
- Decodes funct3 internally and runs shift-add multiply or restoring divide over several cycles.
- Uses a valid/ready handshake on both input and output, so the pipeline can stall on it.
- Parametrised in data width and bits retired per cycle.

Parameters:
XLEN, 32, operand/result width; 32 or 64.
BITS_PER_CYCLE, 1, bits of multiplier/quotient retired per CALC cycle; 1, 2 or 4; must divide XLEN (elaboration error otherwise).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
flush  in  1  synchronous abort; drops any op in flight.
in_valid  in  1  request valid.
in_ready  out  1  unit can accept; high only in IDLE.
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_a  in  XLEN  rs1 value.
op_b  in  XLEN  rs2 value.
out_valid  out  1  result valid; high only in DONE.
out_ready  in  1  consumer accepts result.
result  out  XLEN  result; stable while out_valid is high and out_ready is low.
busy  out  1  high in CALC or DONE.

Behaviour:
- Reset and outputs:
  - Reset gives state IDLE, out_valid=0, result=0, busy=0, in_ready=1 and clears all internal registers.
- States: IDLE, CALC, DONE. N = XLEN/BITS_PER_CYCLE.
- IDLE:
  - in_valid & in_ready captures funct3, op_a and op_b.
  - The signs are recorded and magnitudes are taken:
    - MUL/MULH/DIV/REM: both operands signed.
    - MULHSU: op_a signed, op_b unsigned.
    - All other ops: unsigned.
  - A special case goes straight to DONE; every other op goes to CALC with the counter set to N.
- Special cases (divide ops only; result written on the accept edge):
  - Divisor=0: DIV/DIVU return all-ones; REM/REMU return op_a.
  - Signed overflow (op_a=MIN, op_b=-1, DIV/REM only): DIV returns MIN; REM returns 0.
- CALC:
  - Each edge retires BITS_PER_CYCLE steps and decrements the counter.
  - Multiply: 2*XLEN-bit shift-add on magnitudes.
  - Divide: restoring; partial remainder XLEN+1 bits.
  - When the counter reaches 1 the next edge moves to DONE and registers the sign-corrected result:
    - MUL: low XLEN bits of the product.
    - MULH/MULHSU/MULHU: high XLEN bits of the product, negated as a 2*XLEN value if the product sign is negative.
    - Quotient sign = sign_a XOR sign_b.
    - Remainder sign = sign_a.
- DONE:
  - out_valid=1.
  - out_valid & out_ready sends the unit to IDLE on that edge, with out_valid=0 the next cycle.
  - The unit holds indefinitely under backpressure; result does not change.
- Latency:
  - Normal ops: accept on edge k gives out_valid high after edge k+N (32 cycles for XLEN=32, BPC=1).
  - Special cases: out_valid high after edge k.
- No back-to-back overlap: in_ready=0 from the accept edge until the DONE handshake edge.
- flush:
  - Has priority over all transitions: next state IDLE, out_valid=0, result unchanged.
  - flush together with in_valid in IDLE does not accept.
- rst_n low mid-operation:
  - Immediate return to the reset values; the op is lost and nothing is emitted.
- funct3 is decoded only from the captured copy, so input changes after acceptance have no effect.

Test Plan:
- Reset/idle: assert rst_n=0 mid-CALC -> out_valid, busy and result go to 0 at once, in_ready goes to 1, and no result appears after release.
- MUL 7 * 0xFFFFFFFD -> 0xFFFFFFEB; MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF. Each shows out_valid exactly 32 cycles after accept (BPC=1).
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- Special cases: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Each has out_valid 1 cycle after accept.
- Handshake:
  - Hold out_ready=0 for 5 cycles in DONE -> result is stable and in_ready=0 throughout.
  - Change op_a/funct3 during CALC -> result is unaffected.
  - A new op issued on the cycle after the handshake is accepted.
- flush at CALC cycle 10 -> IDLE next cycle, out_valid is never raised, and the following MUL 3*4 returns 12. Repeat the MUL and DIV cases with XLEN=64, BPC=4 -> latency 16 cycles.
